// File: rtl/sdr_tune_ctrl.sv
// sdr_tune_ctrl: byte-command decoder and tuning register file for the
// 1-bit SDR receiver, with hex entry, hex readback and ACK/NAK replies.
//
// Ports:
//   clk, rst_n         80 MHz clock, async active-low reset
//   rx_dv, rx_byte     received byte strobe and data from uart_rx
//   tx_ready           uart_tx can take a byte
//   tx_valid, tx_byte  response / readback byte toward uart_tx
//   phase_inc          NCO phase increment
//   cic_gain           CIC gain select
//   tune_stb           one-cycle pulse per applied tune command
//   busy               readback in progress
module sdr_tune_ctrl #(
  parameter int PHASE_WIDTH = 64,
  parameter int GAIN_WIDTH = 8,
  parameter int GAIN_MAX = 3,
  parameter logic [PHASE_WIDTH-1:0] RESET_INC = '0,
  parameter logic [PHASE_WIDTH-1:0] PRESET_A = 64'h4CF41F212D77318,
  parameter logic [PHASE_WIDTH-1:0] PRESET_B = 64'h1aa60f8b8911654,
  parameter logic [PHASE_WIDTH-1:0] PRESET_F = 64'h1dc38c076704516d,
  parameter logic [PHASE_WIDTH-1:0] PRESET_G = 64'h1d60d923295482c6,
  parameter logic [PHASE_WIDTH-1:0] STEP_L = 64'h71b375868d170,
  parameter logic [PHASE_WIDTH-1:0] STEP_M = 64'hca22980ba57e,
  parameter logic [PHASE_WIDTH-1:0] STEP_S = 64'h1436a8cdf6f3,
  parameter logic [PHASE_WIDTH-1:0] MAX_INC = 64'h8000_0000_0000_0000,
  parameter int TIMEOUT_CLKS = 8_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_dv,
  input  logic [7:0]             rx_byte,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_byte,
  output logic [PHASE_WIDTH-1:0] phase_inc,
  output logic [GAIN_WIDTH-1:0]  cic_gain,
  output logic                   tune_stb,
  output logic                   busy
);

  localparam int ND = PHASE_WIDTH / 4;
  localparam int DW = $clog2(ND + 1);
  localparam int RW = $clog2(ND + 2);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h45;
  localparam logic [7:0] LF  = 8'h0A;

  typedef enum logic [1:0] {IDLE, HEX, READBACK} state_t;

  state_t                 state;
  logic [PHASE_WIDTH-1:0] shadow;
  logic [PHASE_WIDTH-1:0] rb_word;
  logic [DW-1:0]          digit_cnt;
  logic [RW-1:0]          rb_cnt;
  logic [TW-1:0]          timer;

  function automatic logic [PHASE_WIDTH-1:0] clamp(
    input logic [PHASE_WIDTH-1:0] v
  );
    return (v > MAX_INC) ? MAX_INC : v;
  endfunction

  function automatic logic [PHASE_WIDTH-1:0] step(
    input logic [PHASE_WIDTH-1:0] p,
    input logic [PHASE_WIDTH-1:0] s,
    input logic                   up
  );
    logic signed [PHASE_WIDTH:0] r;
    if (up) r = $signed({1'b0, p}) + $signed({1'b0, s});
    else    r = $signed({1'b0, p}) - $signed({1'b0, s});
    if (r < 0) return '0;
    if (r > $signed({1'b0, MAX_INC})) return MAX_INC;
    return r[PHASE_WIDTH-1:0];
  endfunction

  logic                   is_dig;
  logic                   gain_ok;
  logic                   hex_ok;
  logic [3:0]             hex_nib;
  logic                   is_tune;
  logic [PHASE_WIDTH-1:0] tune_val;
  logic [PHASE_WIDTH-1:0] shadow_nx;
  logic                   hex_last;
  logic [3:0]             rb_nib;
  logic [7:0]             rb_char;

  always_comb begin
    is_dig  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    gain_ok = is_dig && (int'(rx_byte[3:0]) <= GAIN_MAX);
    hex_ok  = 1'b1;
    hex_nib = rx_byte[3:0];
    unique case (1'b1)
      is_dig: hex_nib = rx_byte[3:0];
      (rx_byte >= 8'h61) && (rx_byte <= 8'h66),
      (rx_byte >= 8'h41) && (rx_byte <= 8'h46):
        hex_nib = rx_byte[3:0] + 4'd9;
      default: hex_ok = 1'b0;
    endcase
    shadow_nx = {shadow[PHASE_WIDTH-5:0], hex_nib};
    hex_last  = (digit_cnt == DW'(ND - 1));
  end

  always_comb begin
    is_tune  = 1'b1;
    tune_val = phase_inc;
    unique case (rx_byte)
      "a": tune_val = clamp(PRESET_A);
      "b": tune_val = clamp(PRESET_B);
      "f": tune_val = clamp(PRESET_F);
      "g": tune_val = clamp(PRESET_G);
      "n": tune_val = step(phase_inc, STEP_L, 1'b0);
      "m": tune_val = step(phase_inc, STEP_L, 1'b1);
      "q": tune_val = step(phase_inc, STEP_M, 1'b0);
      "r": tune_val = step(phase_inc, STEP_M, 1'b1);
      "o": tune_val = step(phase_inc, STEP_S, 1'b0);
      "p": tune_val = step(phase_inc, STEP_S, 1'b1);
      default: is_tune = 1'b0;
    endcase
  end

  always_comb begin
    rb_nib  = rb_word[PHASE_WIDTH-1 -: 4];
    rb_char = (rb_nib < 4'd10) ? 8'h30 + {4'b0, rb_nib}
                               : 8'h37 + {4'b0, rb_nib};
  end

  // One candidate byte per cycle: a command reply or the next
  // readback character. It only lands when the slot is free.
  logic       resp_en;
  logic [7:0] resp_byte;
  logic       slot_free;
  logic       xfer;

  assign xfer      = tx_valid && tx_ready;
  assign slot_free = !tx_valid || tx_ready;

  always_comb begin
    resp_en   = 1'b0;
    resp_byte = NAK;
    unique case (state)
      IDLE: begin
        if (rx_dv) begin
          unique case (1'b1)
            is_dig: begin
              resp_en   = 1'b1;
              resp_byte = gain_ok ? ACK : NAK;
            end
            is_tune: begin
              resp_en   = 1'b1;
              resp_byte = ACK;
            end
            (rx_byte == "x"), (rx_byte == "?"): resp_en = 1'b0;
            default: resp_en = 1'b1;
          endcase
        end
      end
      HEX: begin
        if (rx_dv && (!hex_ok || hex_last)) begin
          resp_en   = 1'b1;
          resp_byte = hex_ok ? ACK : NAK;
        end
      end
      READBACK: begin
        if (rb_cnt <= RW'(ND)) begin
          resp_en   = 1'b1;
          resp_byte = (rb_cnt == RW'(ND)) ? LF : rb_char;
        end
      end
      default: resp_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_inc <= RESET_INC;
      cic_gain  <= '0;
      tx_valid  <= 1'b0;
      tx_byte   <= '0;
      tune_stb  <= 1'b0;
      busy      <= 1'b0;
      shadow    <= '0;
      rb_word   <= '0;
      digit_cnt <= '0;
      rb_cnt    <= '0;
      timer     <= '0;
    end else begin
      tune_stb <= 1'b0;
      if (xfer) tx_valid <= 1'b0;
      if (resp_en && slot_free) begin
        tx_valid <= 1'b1;
        tx_byte  <= resp_byte;
      end
      unique case (state)
        IDLE: begin
          if (rx_dv) begin
            unique case (1'b1)
              is_dig: begin
                if (gain_ok) cic_gain <= GAIN_WIDTH'(rx_byte[3:0]);
              end
              is_tune: begin
                phase_inc <= tune_val;
                tune_stb  <= 1'b1;
              end
              (rx_byte == "x"): begin
                state     <= HEX;
                shadow    <= '0;
                digit_cnt <= '0;
                timer     <= '0;
              end
              (rx_byte == "?"): begin
                state   <= READBACK;
                busy    <= 1'b1;
                rb_word <= phase_inc;
                rb_cnt  <= '0;
              end
              default: ;
            endcase
          end
        end
        HEX: begin
          if (rx_dv) begin
            timer <= '0;
            if (!hex_ok) begin
              state <= IDLE;
            end else begin
              shadow    <= shadow_nx;
              digit_cnt <= digit_cnt + 1'b1;
              if (hex_last) begin
                phase_inc <= clamp(shadow_nx);
                tune_stb  <= 1'b1;
                state     <= IDLE;
              end
            end
          end else if (timer == TW'(TIMEOUT_CLKS - 1)) begin
            state  <= IDLE;
            shadow <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        READBACK: begin
          if (resp_en && slot_free) begin
            rb_cnt  <= rb_cnt + 1'b1;
            rb_word <= rb_word << 4;
          end
          // Only the line feed is outstanding once rb_cnt passes ND.
          if (xfer && rb_cnt == RW'(ND + 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_tune_ctrl.sv
// tb_sdr_tune_ctrl: directed self-checking bench for sdr_tune_ctrl.
// Short hex-entry timeout keeps the run small.
module tb_sdr_tune_ctrl;

  localparam int TO = 40;
  localparam logic [63:0] MAXI = 64'h8000_0000_0000_0000;
  localparam logic [7:0] K = 8'h4B;
  localparam logic [7:0] E = 8'h45;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic [63:0] phase_inc;
  logic [7:0]  cic_gain;
  logic        tune_stb;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sdr_tune_ctrl #(.TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .phase_inc(phase_inc), .cic_gain(cic_gain),
    .tune_stb(tune_stb), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_dv = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (phase_inc !== 64'h0 || cic_gain !== 8'h0 || tx_valid !== 1'b0 ||
        tx_byte !== 8'h0 || tune_stb !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset: inc=%h gain=%h v=%b b=%h stb=%b busy=%b want all 0",
               phase_inc, cic_gain, tx_valid, tx_byte, tune_stb, busy);
      errors++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_preset();
    send("a");
    checks++;
    if (phase_inc !== 64'h4CF41F212D77318) begin
      $display("FAIL preset_a: got %h want 04cf41f212d77318", phase_inc);
      errors++;
    end
    checks++;
    if (tune_stb !== 1'b1 || tx_valid !== 1'b1 || tx_byte !== K) begin
      $display("FAIL preset_a_resp: stb=%b v=%b b=%h want 1 1 4b",
               tune_stb, tx_valid, tx_byte);
      errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (tune_stb !== 1'b0 || tx_valid !== 1'b0) begin
      $display("FAIL preset_a_pulse: stb=%b v=%b want 0 0", tune_stb, tx_valid);
      errors++;
    end
  endtask

  task automatic test_clamp();
    do_reset();
    send("o");
    checks++;
    if (phase_inc !== 64'h0 || tune_stb !== 1'b1 || tx_byte !== K) begin
      $display("FAIL clamp_low: inc=%h stb=%b b=%h want 0 1 4b",
               phase_inc, tune_stb, tx_byte);
      errors++;
    end
    send("p");
    checks++;
    if (phase_inc !== 64'h1436a8cdf6f3) begin
      $display("FAIL step_p: got %h want 1436a8cdf6f3", phase_inc);
      errors++;
    end
    send("r");
    checks++;
    if (phase_inc !== 64'hDE5940D99C71) begin
      $display("FAIL step_r: got %h want de5940d99c71", phase_inc);
      errors++;
    end
    send("q");
    checks++;
    if (phase_inc !== 64'h1436a8cdf6f3) begin
      $display("FAIL step_q: got %h want 1436a8cdf6f3", phase_inc);
      errors++;
    end
    send_str("xffffffffffffffff");
    checks++;
    if (phase_inc !== MAXI || tx_byte !== K || tune_stb !== 1'b1) begin
      $display("FAIL hex_clamp: inc=%h b=%h stb=%b want %h 4b 1",
               phase_inc, tx_byte, tune_stb, MAXI);
      errors++;
    end
    send("m");
    checks++;
    if (phase_inc !== MAXI || tx_byte !== K || tune_stb !== 1'b1) begin
      $display("FAIL clamp_high: inc=%h b=%h stb=%b want %h 4b 1",
               phase_inc, tx_byte, tune_stb, MAXI);
      errors++;
    end
    send("n");
    checks++;
    if (phase_inc !== 64'h7FF8E4C8A7972E90) begin
      $display("FAIL step_n: got %h want 7ff8e4c8a7972e90", phase_inc);
      errors++;
    end
  endtask

  task automatic test_hex_readback();
    string exp_s;
    logic [7:0] got[$];
    bit done;
    int bad;
    bit held;
    logic [7:0] held_b;
    exp_s = "0123456789ABCDEF\n";
    send("x");
    checks++;
    if (tx_valid !== 1'b0) begin
      $display("FAIL x_silent: tx_valid=%b want 0", tx_valid);
      errors++;
    end
    send_str("0123456789abcdef");
    checks++;
    if (phase_inc !== 64'h0123456789ABCDEF || tx_byte !== K ||
        tune_stb !== 1'b1) begin
      $display("FAIL hex_load: inc=%h b=%h stb=%b want 0123456789abcdef 4b 1",
               phase_inc, tx_byte, tune_stb);
      errors++;
    end
    send("?");
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) begin
      $display("FAIL rb_start: busy=%b v=%b want 1 0", busy, tx_valid);
      errors++;
    end
    done = 0;
    bad = 0;
    held = 0;
    held_b = 8'h00;
    for (int i = 0; i < 400 && !done; i++) begin
      if (held && (tx_valid !== 1'b1 || tx_byte !== held_b)) bad++;
      tx_ready = 1'($urandom_range(0, 1));
      rx_dv = (i == 6);
      rx_byte = "a";
      held = tx_valid && !tx_ready;
      held_b = tx_byte;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_byte);
        if (tx_byte == 8'h0A) done = 1;
      end
      @(posedge clk); #1;
    end
    rx_dv = 1'b0;
    tx_ready = 1'b1;
    checks++;
    if (bad != 0) begin
      $display("FAIL rb_stable: %0d unstable cycles want 0", bad);
      errors++;
    end
    checks++;
    if (!done || got.size() != 17) begin
      $display("FAIL rb_len: done=%0d bytes=%0d want 1 17", done, got.size());
      errors++;
    end else begin
      bad = 0;
      for (int i = 0; i < 17; i++) if (got[i] !== exp_s[i]) bad++;
      if (bad != 0) begin
        $display("FAIL rb_stream: %0d wrong bytes, first got %h want %h",
                 bad, got[0], exp_s[0]);
        errors++;
      end
    end
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 ||
        phase_inc !== 64'h0123456789ABCDEF) begin
      $display("FAIL rb_end: busy=%b v=%b inc=%h want 0 0 0123456789abcdef",
               busy, tx_valid, phase_inc);
      errors++;
    end
  endtask

  task automatic test_hex_abort();
    send_str("x12z");
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== E || tune_stb !== 1'b0 ||
        phase_inc !== 64'h0123456789ABCDEF) begin
      $display("FAIL hex_abort: v=%b b=%h stb=%b inc=%h want 1 45 0 0123456789abcdef",
               tx_valid, tx_byte, tune_stb, phase_inc);
      errors++;
    end
    send("1");
    checks++;
    if (cic_gain !== 8'd1 || tx_byte !== K) begin
      $display("FAIL abort_idle: gain=%0d b=%h want 1 4b", cic_gain, tx_byte);
      errors++;
    end
  endtask

  task automatic test_timeout();
    int seen;
    send_str("x1");
    seen = 0;
    for (int i = 0; i < TO - 2; i++) begin
      @(posedge clk); #1;
      if (tx_valid) seen++;
    end
    send("2");
    checks++;
    if (tx_valid !== 1'b0 || cic_gain !== 8'd1 || seen != 0) begin
      $display("FAIL timeout_edge: v=%b gain=%0d seen=%0d want 0 1 0",
               tx_valid, cic_gain, seen);
      errors++;
    end
    for (int i = 0; i < TO - 1; i++) begin
      @(posedge clk); #1;
      if (tx_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      $display("FAIL timeout_silent: %0d responses want 0", seen);
      errors++;
    end
    send("2");
    checks++;
    if (cic_gain !== 8'd2 || tx_valid !== 1'b1 || tx_byte !== K ||
        phase_inc !== 64'h0123456789ABCDEF) begin
      $display("FAIL timeout_idle: gain=%0d v=%b b=%h inc=%h want 2 1 4b 0123456789abcdef",
               cic_gain, tx_valid, tx_byte, phase_inc);
      errors++;
    end
  endtask

  task automatic test_gain();
    send("3");
    checks++;
    if (cic_gain !== 8'd3 || tx_byte !== K || tune_stb !== 1'b0) begin
      $display("FAIL gain_3: gain=%0d b=%h stb=%b want 3 4b 0",
               cic_gain, tx_byte, tune_stb);
      errors++;
    end
    send("7");
    checks++;
    if (cic_gain !== 8'd3 || tx_byte !== E) begin
      $display("FAIL gain_7: gain=%0d b=%h want 3 45", cic_gain, tx_byte);
      errors++;
    end
    send("Z");
    checks++;
    if (cic_gain !== 8'd3 || tx_byte !== E || tx_valid !== 1'b1 ||
        phase_inc !== 64'h0123456789ABCDEF) begin
      $display("FAIL unknown: gain=%0d b=%h v=%b inc=%h want 3 45 1 0123456789abcdef",
               cic_gain, tx_byte, tx_valid, phase_inc);
      errors++;
    end
  endtask

  task automatic test_drop();
    @(posedge clk); #1;
    tx_ready = 1'b0;
    send("1");
    send("Z");
    checks++;
    if (cic_gain !== 8'd1 || tx_valid !== 1'b1 || tx_byte !== K) begin
      $display("FAIL drop_hold: gain=%0d v=%b b=%h want 1 1 4b",
               cic_gain, tx_valid, tx_byte);
      errors++;
    end
    send("2");
    checks++;
    if (cic_gain !== 8'd2 || tx_byte !== K) begin
      $display("FAIL drop_exec: gain=%0d b=%h want 2 4b", cic_gain, tx_byte);
      errors++;
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b0) begin
      $display("FAIL drop_drain: v=%b want 0", tx_valid);
      errors++;
    end
  endtask

  task automatic test_reset_mid_readback();
    tx_ready = 1'b0;
    send("?");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_byte !== 8'h30) begin
      $display("FAIL rb_wait: busy=%b v=%b b=%h want 1 1 30",
               busy, tx_valid, tx_byte);
      errors++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || phase_inc !== 64'h0) begin
      $display("FAIL async_reset: v=%b busy=%b inc=%h want 0 0 0",
               tx_valid, busy, phase_inc);
      errors++;
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send("b");
    checks++;
    if (phase_inc !== 64'h1aa60f8b8911654 || tx_byte !== K ||
        tune_stb !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL after_reset_b: inc=%h b=%h stb=%b busy=%b want 01aa60f8b8911654 4b 1 0",
               phase_inc, tx_byte, tune_stb, busy);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_preset();
    test_clamp();
    test_hex_readback();
    test_hex_abort();
    test_timeout();
    test_gain();
    test_drop();
    test_reset_mid_readback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
